// File: rtl/hs_tx_bridge.sv
// Bridge from a clocked valid/ready source to a 4-phase bundled-data micropipeline stage.
// Words are queued in a small FIFO and issued one per handshake; ack_in is synchronised before use.
module hs_tx_bridge #(
    parameter int DATA_W      = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     req_out,
    input  logic                     ack_in,
    output logic [DATA_W-1:0]        data_out,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [SYNC_STAGES-1:0]   ack_sync_q;
    logic                     req_q, req_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     ack_s;
    logic                     push;
    logic                     pop;

    assign ack_s      = ack_sync_q[SYNC_STAGES-1];
    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign push       = in_valid & in_ready;
    assign req_out    = req_q;
    assign data_out   = data_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE);

    // ack_in is asynchronous to clk; only the last flop of this chain feeds the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_in};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            // Holding here while ack_s is high rejects a stale acknowledge.
            SETUP: begin
                if (!ack_s) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        req_d    = (state_d == REQ);
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            data_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            req_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            req_q    <= req_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_hs_tx_bridge.sv
// Bench for hs_tx_bridge: a queue of accepted words is the reference; every request must carry its head.
module tb_hs_tx_bridge;

    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              req_out;
    logic              ack_in = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;

    // 0: ack follows req (4-phase stage model), 1: held low, 2: held high
    logic [1:0]        ack_mode = 2'd1;
    logic              ack_rand = 1'b0;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] sb[$];
    logic              req_prev = 1'b0;
    logic [DATA_W-1:0] data_prev = '0;

    hs_tx_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .req_out    (req_out),
        .ack_in     (ack_in),
        .data_out   (data_out),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always begin
        #1;
        if (ack_mode == 2'd1) begin
            ack_in = 1'b0;
        end else if (ack_mode == 2'd2) begin
            ack_in = 1'b1;
        end else if (ack_in != req_out) begin
            if (ack_rand) #($urandom_range(1, 30));
            else #3;
            if (ack_mode == 2'd0) ack_in = req_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int c = 0;
        while ((busy || fifo_count != '0) && c < maxc) begin
            tick();
            c++;
        end
        chk(name, {31'd0, (busy || fifo_count != '0)}, 32'd0);
    endtask

    task automatic wait_busy_low(input int maxc, input string name);
        int c = 0;
        while (busy && c < maxc) begin
            tick();
            c++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        fork
            begin : stimulus
                logic [DATA_W-1:0] burst [6];
                burst = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};

                // Reset with in_valid asserted: nothing may be pushed.
                rst = 1'b1; in_valid = 1'b1; in_data = 2'b11;
                tick(); tick();
                chk("rst_req", {31'd0, req_out}, 32'd0);
                chk("rst_data", {30'd0, data_out}, 32'd0);
                chk("rst_count", {29'd0, fifo_count}, 32'd0);
                chk("rst_ready", {31'd0, in_ready}, 32'd1);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                in_valid = 1'b0; rst = 1'b0; ack_mode = 2'd0;
                tick();
                chk("post_rst_count", {29'd0, fifo_count}, 32'd0);

                // Single transfer latency.
                push_word(2'b01);
                chk("single_cnt_e0", {29'd0, fifo_count}, 32'd1);
                chk("single_busy_e0", {31'd0, busy}, 32'd0);
                tick();
                chk("single_data_e1", {30'd0, data_out}, 32'd1);
                chk("single_busy_e1", {31'd0, busy}, 32'd1);
                chk("single_req_e1", {31'd0, req_out}, 32'd0);
                tick();
                chk("single_req_e2", {31'd0, req_out}, 32'd1);
                tick(); tick();
                chk("single_req_e4", {31'd0, req_out}, 32'd1);
                tick();
                chk("single_req_e5", {31'd0, req_out}, 32'd0);
                tick(); tick();
                chk("single_busy_e7", {31'd0, busy}, 32'd1);
                tick();
                chk("single_busy_e8", {31'd0, busy}, 32'd0);

                // Burst against a stalled stage.
                ack_mode = 2'd1;
                for (int i = 0; i < 6; i++) begin
                    in_valid = 1'b1;
                    in_data  = burst[i];
                    tick();
                end
                in_valid = 1'b0;
                chk("burst_count", {29'd0, fifo_count}, 32'd4);
                chk("burst_ready", {31'd0, in_ready}, 32'd0);
                chk("burst_data", {30'd0, data_out}, 32'd0);
                chk("burst_req", {31'd0, req_out}, 32'd1);
                ack_mode = 2'd0;
                wait_idle(200, "burst_drain");

                // Push on the same edge the FSM pops.
                ack_mode = 2'd1;
                push_word(2'b01); push_word(2'b10); push_word(2'b00);
                ack_mode = 2'd0;
                wait_busy_low(40, "simul_wait_idle");
                chk("simul_count_before", {29'd0, fifo_count}, 32'd2);
                push_word(2'b11);
                chk("simul_count_after", {29'd0, fifo_count}, 32'd2);
                chk("simul_busy", {31'd0, busy}, 32'd1);
                chk("simul_data", {30'd0, data_out}, 32'd2);
                wait_idle(200, "simul_drain");

                // Stale ack held high before the word arrives.
                ack_mode = 2'd2;
                tick(); tick(); tick();
                push_word(2'b10);
                tick(); tick(); tick();
                chk("spur_req_hold", {31'd0, req_out}, 32'd0);
                chk("spur_busy", {31'd0, busy}, 32'd1);
                chk("spur_data", {30'd0, data_out}, 32'd2);
                ack_mode = 2'd0;
                tick();
                chk("spur_req_a", {31'd0, req_out}, 32'd0);
                tick();
                chk("spur_req_b", {31'd0, req_out}, 32'd0);
                tick();
                chk("spur_req_c", {31'd0, req_out}, 32'd1);
                wait_idle(200, "spur_drain");

                // Reset in the middle of a handshake.
                ack_mode = 2'd1;
                push_word(2'b01); push_word(2'b10); push_word(2'b11); push_word(2'b00);
                chk("mid_req", {31'd0, req_out}, 32'd1);
                chk("mid_count", {29'd0, fifo_count}, 32'd3);
                rst = 1'b1;
                tick();
                chk("mid_rst_req", {31'd0, req_out}, 32'd0);
                chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
                chk("mid_rst_busy", {31'd0, busy}, 32'd0);
                chk("mid_rst_data", {30'd0, data_out}, 32'd0);
                rst = 1'b0; ack_mode = 2'd0;
                tick(); tick();
                push_word(2'b11);
                tick();
                chk("mid_new_data", {30'd0, data_out}, 32'd3);
                wait_idle(200, "mid_drain");

                // Random traffic with random stage response times.
                ack_rand = 1'b1;
                for (int i = 0; i < 300; i++) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = DATA_W'($urandom);
                    tick();
                end
                in_valid = 1'b0;
                wait_idle(2000, "rand_drain");
                tick(); tick();
                chk("sb_empty", sb.size(), 32'd0);
            end
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        sb.delete();
                    end else begin
                        if (in_valid && in_ready) sb.push_back(in_data);
                        if (req_out && !req_prev) begin
                            if (sb.size() == 0) begin
                                chk("sb_unexpected_req", 32'd1, 32'd0);
                            end else begin
                                chk("sb_data", {30'd0, data_out}, {30'd0, sb.pop_front()});
                            end
                        end
                        if (req_out && req_prev) begin
                            chk("data_stable", {30'd0, data_out}, {30'd0, data_prev});
                        end
                    end
                    req_prev  = req_out;
                    data_prev = data_out;
                end
            end
            begin : watchdog
                #400us;
                $display("FAIL watchdog: got timeout expected completion");
                n_errors++;
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
